cpu_board_ctrl: RTL and testbench

CPU_BOARD_CTRL -- requirements
Module: cpu_board_ctrl

---
 rtl/cpu_board_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_cpu_board_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_board_ctrl.sv
// cpu_board_ctrl: board-level CPU clock generator and 7-segment display driver.
// In free-run mode the CPU clock is a divided-down board clock. In single-step
// mode each debounced button press produces one 4-cycle CPU clock pulse.
// A display register shows a selected 32-bit channel (or the CPU cycle count)
// on an 8-digit multiplexed, active-low 7-segment display.
module cpu_board_ctrl #(
  parameter int CUT_SITES = 26,
  parameter int N_CH      = 4,
  parameter int DB_BITS   = 20,
  parameter int SCAN_BITS = 16,
  parameter int SEL_W     = $clog2(N_CH + 1)
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  step_btn,
  input  logic [SEL_W-1:0]      ch_sel,
  input  logic [N_CH*32-1:0]    ch_data,
  output logic                  cpu_clk,
  output logic                  cpu_tick,
  output logic [7:0]            o_seg,
  output logic [7:0]            o_sel
);

  // Step pulse length in clk_in cycles.
  localparam int unsigned STEP_CYCLES = 4;
  localparam logic [1:0] STEP_LAST = 2'(STEP_CYCLES - 1);
  localparam logic [DB_BITS-1:0] DB_MAX = '1;

  typedef enum logic [0:0] {
    STEP_IDLE  = 1'b0,
    STEP_PULSE = 1'b1
  } step_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [1:0]       mode_sync;
  logic [1:0]       btn_sync;
  logic [SEL_W-1:0] sel_ff1;
  logic [SEL_W-1:0] sel_s;
  logic             mode_s;
  logic             btn_s;

  assign mode_s = mode_sync[1];
  assign btn_s  = btn_sync[1];

  // Two-flop synchronisers for the asynchronous switches and the button.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mode_sync <= '0;
      btn_sync  <= '0;
      sel_ff1   <= '0;
      sel_s     <= '0;
    end else begin
      mode_sync <= {mode_sync[0], mode};
      btn_sync  <= {btn_sync[0], step_btn};
      sel_ff1   <= ch_sel;
      sel_s     <= sel_ff1;
    end
  end

  // ---------------------------------------------------------------------------
  // Step button debounce
  // ---------------------------------------------------------------------------
  logic [DB_BITS-1:0] db_cnt;
  logic               db_stable;
  logic               press;

  // A press is the stable level flipping 0->1; releases never count.
  assign press = btn_s && !db_stable && (db_cnt == DB_MAX);

  // Restart the stability window whenever the input agrees with the stable
  // level; adopt the new level once it has held for the whole window.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      db_cnt    <= '0;
      db_stable <= 1'b0;
    end else if (btn_s == db_stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_MAX) begin
      db_stable <= btn_s;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU clock generation: free-run divider and single-step pulse FSM
  // ---------------------------------------------------------------------------
  step_state_t          step_state, step_state_next;
  logic [1:0]           step_len, step_len_next;
  logic [CUT_SITES:0]   cnt, cnt_next;
  logic                 cpu_clk_next;
  logic                 tick_next;

  // Next-state logic for the divider, step pulse and the CPU clock level.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    step_state_next = step_state;
    step_len_next   = step_len;
    cnt_next        = cnt + 1'b1;
    cpu_clk_next    = 1'b0;
    if (mode_s) begin
      // Single-step: divider parked at 0, clock follows the pulse FSM.
      cnt_next = '0;
      case (step_state)
        STEP_IDLE: begin
          if (press) begin
            step_state_next = STEP_PULSE;
            step_len_next   = '0;
          end
        end
        STEP_PULSE: begin
          // Presses during an active pulse are dropped, not queued.
          if (step_len == STEP_LAST) begin
            step_state_next = STEP_IDLE;
          end else begin
            step_len_next = step_len + 2'd1;
          end
        end
        default: step_state_next = STEP_IDLE;
      endcase
      cpu_clk_next = (step_state_next == STEP_PULSE);
    end else begin
      // Free-run: any pulse in flight is abandoned; divider MSB is the clock.
      step_state_next = STEP_IDLE;
      step_len_next   = '0;
      cpu_clk_next    = cnt_next[CUT_SITES];
    end
  end

  assign tick_next = cpu_clk_next && !cpu_clk;

  // Register the divider, pulse FSM, CPU clock and its rising-edge tick.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      step_state <= STEP_IDLE;
      step_len   <= '0;
      cnt        <= '0;
      cpu_clk    <= 1'b0;
      cpu_tick   <= 1'b0;
    end else begin
      step_state <= step_state_next;
      step_len   <= step_len_next;
      cnt        <= cnt_next;
      cpu_clk    <= cpu_clk_next;
      cpu_tick   <= tick_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter and display register
  // ---------------------------------------------------------------------------
  logic [31:0]      cyc, cyc_next;
  logic [31:0]      disp;
  logic [31:0]      disp_src;
  logic [SEL_W-1:0] sel_prev;
  logic             sel_chg;

  // cyc advances as the tick cycle ends; the display sees the advanced value
  // so a tick shows the new count rather than the previous one.
  assign cyc_next = cpu_tick ? cyc + 32'd1 : cyc;
  assign sel_chg  = (sel_s != sel_prev);

  // Display source: an input channel, or the cycle count for out-of-range
  // selects.
  always_comb begin
    disp_src = cyc_next;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(sel_s) == k) disp_src = ch_data[32*k +: 32];
    end
  end

  // Count CPU cycles; reload the display on each tick or a channel change.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cyc      <= '0;
      disp     <= '0;
      sel_prev <= '0;
    end else begin
      cyc      <= cyc_next;
      sel_prev <= sel_s;
      if (cpu_tick || sel_chg) disp <= disp_src;
    end
  end

  // ---------------------------------------------------------------------------
  // Seven-segment scan
  // ---------------------------------------------------------------------------
  logic [SCAN_BITS+2:0] scan_cnt;
  logic [2:0]           idx;

  assign idx = scan_cnt[SCAN_BITS+2:SCAN_BITS];

  // Hex digit to active-low {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  // Free-running scan; drive one active-low digit enable and its segments.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      o_sel    <= 8'hFF;
      o_seg    <= 8'hFF;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      o_sel    <= ~(8'b1 << idx);
      o_seg    <= hex_seg(disp[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_cpu_board_ctrl.sv
// tb_cpu_board_ctrl: self-checking bench for cpu_board_ctrl with small
// parameters (CUT_SITES=3, DB_BITS=2, SCAN_BITS=1, N_CH=4).
module tb_cpu_board_ctrl;

  localparam int CUT_SITES = 3;
  localparam int N_CH      = 4;
  localparam int DB_BITS   = 2;
  localparam int SCAN_BITS = 1;
  localparam int SEL_W     = 3;

  logic               clk_in = 1'b0;
  logic               reset;
  logic               mode;
  logic               step_btn;
  logic [SEL_W-1:0]   ch_sel;
  logic [N_CH*32-1:0] ch_data;
  logic               cpu_clk;
  logic               cpu_tick;
  logic [7:0]         o_seg;
  logic [7:0]         o_sel;

  cpu_board_ctrl #(
    .CUT_SITES(CUT_SITES),
    .N_CH     (N_CH),
    .DB_BITS  (DB_BITS),
    .SCAN_BITS(SCAN_BITS)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .mode    (mode),
    .step_btn(step_btn),
    .ch_sel  (ch_sel),
    .ch_data (ch_data),
    .cpu_clk (cpu_clk),
    .cpu_tick(cpu_tick),
    .o_seg   (o_seg),
    .o_sel   (o_sel)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference segment patterns for 0..F.
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Scoreboard of expected results, consumed in order as results appear.
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Display vectors: select a channel, expect a given digit's segments.
  typedef struct {
    logic [SEL_W-1:0] sel;
    int               dig;
    logic [7:0]       seg;
  } vec_t;
  vec_t vecs[16];

  // One-hot digit enable monitor.
  bit mon_en = 1'b0;
  int onehot_err = 0;
  always @(negedge clk_in) begin
    if (mon_en && ($countones(~o_sel) != 1)) onehot_err++;
  end

  // Watchdog: never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_underflow: got %h expected nothing", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [4:0] decode_seg(input logic [7:0] s);
    for (int i = 0; i < 16; i++) begin
      if (hex_tab[i] == s) return {1'b1, i[3:0]};
    end
    return 5'b0;
  endfunction

  // Reassemble the displayed 32-bit value over one full scan (16 cycles).
  task automatic read_display(output logic [31:0] val);
    logic [4:0] d;
    logic [7:0] want;
    val = 'x;
    for (int c = 0; c < 16; c++) begin
      step_clk();
      for (int i = 0; i < 8; i++) begin
        want = ~(8'b1 << i);
        if (o_sel == want) begin
          d = decode_seg(o_seg);
          val[4*i +: 4] = d[4] ? d[3:0] : 4'hx;
        end
      end
    end
  endtask

  // Hold the step button for 'hold' edges, then watch the CPU clock.
  task automatic press_and_watch(input int hold, output int highs, output int ticks,
                                 output int rises);
    logic prev;
    highs = 0;
    ticks = 0;
    rises = 0;
    prev  = cpu_clk;
    step_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == hold) step_btn = 1'b0;
      step_clk();
      if (cpu_clk) highs++;
      if (cpu_tick) ticks++;
      if (cpu_clk && !prev) rises++;
      prev = cpu_clk;
    end
  endtask

  initial begin
    logic [31:0] v;
    int highs, ticks, rises, last_rise, period, tick_err, run, max_run;
    int rise_at, fall_at, found;
    logic prev_clk;
    logic [7:0] want_sel;

    vecs[0]  = '{3'd1, 0, 8'hA1};  // D
    vecs[1]  = '{3'd1, 7, 8'hF9};  // 1
    vecs[2]  = '{3'd1, 3, 8'h88};  // A
    vecs[3]  = '{3'd0, 0, 8'hC0};  // 0
    vecs[4]  = '{3'd0, 2, 8'hA4};  // 2
    vecs[5]  = '{3'd0, 3, 8'hB0};  // 3
    vecs[6]  = '{3'd0, 4, 8'h99};  // 4
    vecs[7]  = '{3'd0, 6, 8'h82};  // 6
    vecs[8]  = '{3'd0, 7, 8'hF8};  // 7
    vecs[9]  = '{3'd2, 0, 8'h80};  // 8
    vecs[10] = '{3'd2, 1, 8'h90};  // 9
    vecs[11] = '{3'd2, 3, 8'h83};  // B
    vecs[12] = '{3'd2, 4, 8'hC6};  // C
    vecs[13] = '{3'd2, 6, 8'h86};  // E
    vecs[14] = '{3'd2, 7, 8'h8E};  // F
    vecs[15] = '{3'd3, 1, 8'h92};  // 5

    reset    = 1'b1;
    mode     = 1'b0;
    step_btn = 1'b0;
    ch_sel   = '0;
    ch_data  = {32'h0F0F5A5A, 32'hFEDCBA98, 32'h1234ABCD, 32'h76543210};
    #2 reset = 1'b0;
    #20;

    // Reset state.
    sb_push("rst_cpu_clk", 0);
    sb_push("rst_cpu_tick", 0);
    sb_push("rst_o_sel", 32'hFF);
    sb_push("rst_o_seg", 32'hFF);
    sb_check(cpu_clk);
    sb_check(cpu_tick);
    sb_check(o_sel);
    sb_check(o_seg);

    @(negedge clk_in);
    reset = 1'b1;
    step_clk();
    sb_push("first_edge_o_sel", 32'hFE);
    sb_push("first_edge_o_seg", 32'hC0);
    sb_check(o_sel);
    sb_check(o_seg);
    mon_en = 1'b1;

    // Free-run for 64 cycles (the first-edge sample counts as cycle 0).
    sb_push("run_rises", 4);
    sb_push("run_ticks", 4);
    sb_push("run_high_cycles", 32);
    sb_push("run_period", 16);
    sb_push("run_high_len", 8);
    sb_push("run_tick_align_err", 0);
    highs = 0; ticks = 0; rises = 0; last_rise = -1; period = 0;
    tick_err = 0; run = 0; max_run = 0; prev_clk = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) step_clk();
      if (cpu_clk) begin
        highs++;
        run++;
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
      if (cpu_clk && !prev_clk) begin
        rises++;
        if (last_rise >= 0) period = i - last_rise;
        last_rise = i;
      end
      if (cpu_tick !== (cpu_clk && !prev_clk)) tick_err++;
      if (cpu_tick) ticks++;
      prev_clk = cpu_clk;
    end
    sb_check(rises);
    sb_check(ticks);
    sb_check(highs);
    sb_check(period);
    sb_check(max_run);
    sb_check(tick_err);

    // Enter step mode and show the cycle counter.
    mode   = 1'b1;
    ch_sel = 3'd4;
    sb_push("cyc_after_run", 32'h00000004);
    repeat (4) step_clk();
    read_display(v);
    sb_check(v);

    // Clean press with channel 1 shown: one 4-cycle pulse, one tick.
    ch_sel = 3'd1;
    sb_push("step_highs", 4);
    sb_push("step_ticks", 1);
    sb_push("step_rises", 1);
    press_and_watch(10, highs, ticks, rises);
    sb_check(highs);
    sb_check(ticks);
    sb_check(rises);

    // Switch to the cycle counter after five ticks.
    ch_sel = 3'd4;
    sb_push("disp_after_5_ticks", 32'h00000005);
    repeat (4) step_clk();
    read_display(v);
    sb_check(v);

    // Next tick refreshes the display.
    sb_push("step2_ticks", 1);
    sb_push("disp_after_6_ticks", 32'h00000006);
    press_and_watch(10, highs, ticks, rises);
    sb_check(ticks);
    read_display(v);
    sb_check(v);

    // Short glitches never make a pulse.
    sb_push("glitch1_highs", 0);
    sb_push("glitch1_ticks", 0);
    press_and_watch(1, highs, ticks, rises);
    sb_check(highs);
    sb_check(ticks);
    sb_push("glitch2_highs", 0);
    sb_push("glitch2_ticks", 0);
    press_and_watch(2, highs, ticks, rises);
    sb_check(highs);
    sb_check(ticks);

    // Table-driven display vectors.
    for (int i = 0; i < 16; i++) begin
      ch_sel = vecs[i].sel;
      want_sel = ~(8'b1 << vecs[i].dig);
      sb_push($sformatf("vec%0d_seg", i), {24'h0, vecs[i].seg});
      repeat (5) step_clk();
      found = 0;
      for (int j = 0; j < 20; j++) begin
        if (o_sel == want_sel) begin
          found = 1;
          break;
        end
        step_clk();
      end
      if (found != 0) sb_check({24'h0, o_seg});
      else sb_check(32'hFFFFFFFF);
    end

    // Step -> run: first rise 2^CUT_SITES cycles after the divider restarts
    // (two synchroniser cycles, then eight divider counts).
    ch_sel = 3'd4;
    repeat (5) step_clk();
    mode = 1'b0;
    rise_at = -1;
    sb_push("first_run_rise", 10);
    for (int k = 1; k <= 40; k++) begin
      step_clk();
      if (cpu_clk) begin
        rise_at = k;
        break;
      end
    end
    sb_check(rise_at);

    // Run -> step while cpu_clk is high: drops early, no tick, cyc frozen.
    repeat (2) step_clk();
    mode = 1'b1;
    fall_at = -1;
    ticks = 0;
    sb_push("mode_switch_fall_in_3", 1);
    sb_push("mode_switch_ticks", 0);
    sb_push("cyc_after_mode_switch", 32'h00000007);
    for (int k = 1; k <= 10; k++) begin
      step_clk();
      if (cpu_tick) ticks++;
      if (!cpu_clk && fall_at < 0) fall_at = k;
    end
    sb_check((fall_at >= 1) && (fall_at <= 3));
    sb_check(ticks);
    read_display(v);
    sb_check(v);

    // Reset during the second cycle of a step pulse.
    step_btn = 1'b1;
    found = 0;
    sb_push("pulse_before_reset", 1);
    for (int k = 0; k < 20; k++) begin
      step_clk();
      if (cpu_clk) begin
        found = 1;
        break;
      end
    end
    sb_check(found);
    step_clk();
    #2;
    reset    = 1'b0;
    step_btn = 1'b0;
    mon_en   = 1'b0;
    #1;
    sb_push("midpulse_rst_cpu_clk", 0);
    sb_push("midpulse_rst_o_sel", 32'hFF);
    sb_push("midpulse_rst_o_seg", 32'hFF);
    sb_check(cpu_clk);
    sb_check(o_sel);
    sb_check(o_seg);
    @(negedge clk_in);
    reset = 1'b1;
    step_clk();
    sb_push("rerelease_o_sel", 32'hFE);
    sb_push("rerelease_o_seg", 32'hC0);
    sb_check(o_sel);
    sb_check(o_seg);
    mon_en = 1'b1;
    highs = 0;
    sb_push("after_reset_highs", 0);
    for (int k = 0; k < 30; k++) begin
      step_clk();
      if (cpu_clk) highs++;
    end
    sb_check(highs);
    sb_push("cyc_after_reset", 32'h00000000);
    read_display(v);
    sb_check(v);

    check("digit_enable_onehot", onehot_err, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
